// File: rtl/handshake_sink.sv
// Slave-side traffic sink for a valid/ready link: throttled ready, burst length
// tracking, incrementing-sequence data check and sender protocol monitoring.
module handshake_sink #(
  parameter int BITS       = 8,
  parameter int CNT_BITS   = 16,
  parameter int STALL_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [BITS-1:0]       value,
  input  logic                  valid,
  output logic                  ready,
  input  logic                  start,
  input  logic [CNT_BITS-1:0]   length,
  input  logic [BITS-1:0]       seed,
  input  logic [STALL_BITS-1:0] on_cycles,
  input  logic [STALL_BITS-1:0] off_cycles,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_BITS-1:0]   beats,
  output logic                  mismatch,
  output logic                  violation,
  output logic [BITS-1:0]       first_bad
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_BITS-1:0]   CNT_ONE   = CNT_BITS'(1);
  localparam logic [BITS-1:0]       BITS_ONE  = BITS'(1);
  localparam logic [STALL_BITS-1:0] STALL_ONE = STALL_BITS'(1);

  logic [1:0]            state;
  logic [CNT_BITS-1:0]   len_q;
  logic [BITS-1:0]       expected;
  logic [STALL_BITS-1:0] on_q;
  logic [STALL_BITS-1:0] off_q;
  logic [STALL_BITS-1:0] phase_cnt;
  logic                  pending;
  logic [BITS-1:0]       pend_value;

  logic                  accept_start;
  logic                  beat;
  logic                  last_beat;
  logic [STALL_BITS-1:0] on_eff;
  logic                  phase_end;

  assign accept_start = (state == ST_IDLE) && start;
  assign beat         = (state == ST_RUN) && valid && ready;
  assign last_beat    = beat && (beats == len_q - CNT_ONE);
  assign on_eff       = (on_q == '0) ? STALL_ONE : on_q;
  // ready itself marks the current throttle phase while running
  assign phase_end    = ready ? (phase_cnt == on_eff - STALL_ONE)
                              : (phase_cnt == off_q - STALL_ONE);

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= (length != '0) ? ST_RUN : ST_DONE;
        ST_RUN:  if (last_beat) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
      on_q  <= '0;
      off_q <= '0;
    end else if (accept_start) begin
      len_q <= length;
      on_q  <= on_cycles;
      off_q <= off_cycles;
    end
  end

  // Free-running ON/OFF throttle; the final beat forces ready low regardless of phase
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready     <= 1'b0;
      phase_cnt <= '0;
    end else if (accept_start && (length != '0)) begin
      ready     <= 1'b1;
      phase_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (last_beat) begin
        ready     <= 1'b0;
        phase_cnt <= '0;
      end else if (phase_end) begin
        ready     <= !(ready && (off_q != '0));
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + STALL_ONE;
      end
    end else begin
      ready     <= 1'b0;
      phase_cnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beats     <= '0;
      expected  <= '0;
      mismatch  <= 1'b0;
      first_bad <= '0;
    end else if (accept_start) begin
      beats     <= '0;
      expected  <= seed;
      mismatch  <= 1'b0;
      first_bad <= '0;
    end else if (beat) begin
      beats    <= beats + CNT_ONE;
      expected <= expected + BITS_ONE;
      if (value != expected) begin
        mismatch <= 1'b1;
        if (!mismatch) first_bad <= value;
      end
    end
  end

  // A beat offered against ready=0 must be held unchanged until it is taken
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      violation  <= 1'b0;
      pending    <= 1'b0;
      pend_value <= '0;
    end else if (accept_start) begin
      violation  <= 1'b0;
      pending    <= 1'b0;
      pend_value <= '0;
    end else if (state == ST_RUN) begin
      if (pending && (!valid || (value != pend_value))) violation <= 1'b1;
      pending    <= valid && !ready;
      pend_value <= value;
    end else begin
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_handshake_sink.sv
// Bench for handshake_sink: burst table, hand-written corner sequences and a
// random run, all checked every cycle against a cycle-count based reference model.
module tb_handshake_sink;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  value = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        start = 1'b0;
  logic [15:0] length = '0;
  logic [7:0]  seed = '0;
  logic [3:0]  on_cycles = '0;
  logic [3:0]  off_cycles = '0;
  logic        busy;
  logic        done;
  logic [15:0] beats;
  logic        mismatch;
  logic        violation;
  logic [7:0]  first_bad;

  int n_vec = 0;
  int n_bad = 0;

  handshake_sink #(.BITS(8), .CNT_BITS(16), .STALL_BITS(4)) dut (
    .clock(clock), .reset_n(reset_n), .value(value), .valid(valid), .ready(ready),
    .start(start), .length(length), .seed(seed), .on_cycles(on_cycles),
    .off_cycles(off_cycles), .busy(busy), .done(done), .beats(beats),
    .mismatch(mismatch), .violation(violation), .first_bad(first_bad)
  );

  always #5 clock = ~clock;

  // Reference model: phase 0 idle, 1 running, 2 done; m_k counts cycles since the burst began
  int m_phase, m_k, m_len, m_seed, m_on, m_off, m_beats, m_first_bad, m_pend_val;
  bit m_mis, m_viol, m_pend;

  function automatic void model_reset();
    m_phase = 0; m_k = 0; m_len = 0; m_seed = 0; m_on = 0; m_off = 0;
    m_beats = 0; m_first_bad = 0; m_pend_val = 0;
    m_mis = 0; m_viol = 0; m_pend = 0;
  endfunction

  function automatic bit model_ready();
    int on_eff;
    on_eff = (m_on == 0) ? 1 : m_on;
    return (m_phase == 1) && ((m_off == 0) || ((m_k % (on_eff + m_off)) < on_eff));
  endfunction

  function automatic int model_next();
    return (m_seed + m_beats) % 256;
  endfunction

  function automatic void model_step(input bit v, input int val, input bit st);
    bit r;
    r = model_ready();
    case (m_phase)
      0: if (st) begin
        m_len = int'(length); m_seed = int'(seed);
        m_on = int'(on_cycles); m_off = int'(off_cycles);
        m_beats = 0; m_mis = 0; m_viol = 0; m_first_bad = 0;
        m_k = 0; m_pend = 0;
        m_phase = (m_len != 0) ? 1 : 2;
      end
      1: begin
        if (m_pend && (!v || val != m_pend_val)) m_viol = 1;
        m_pend = v && !r;
        m_pend_val = val;
        if (v && r) begin
          if (val != model_next()) begin
            if (!m_mis) m_first_bad = val;
            m_mis = 1;
          end
          m_beats++;
          if (m_beats == m_len) m_phase = 2;
        end
        m_k++;
      end
      default: begin
        m_phase = 0;
        m_pend = 0;
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    chk("ready", ready, int'(model_ready()));
    chk("busy", busy, (m_phase != 0) ? 1 : 0);
    chk("done", done, (m_phase == 2) ? 1 : 0);
    chk("beats", beats, m_beats);
    chk("mismatch", mismatch, int'(m_mis));
    chk("violation", violation, int'(m_viol));
    chk("first_bad", first_bad, m_first_bad);
  endtask

  task automatic applyStimulus(input bit v, input int val, input bit st);
    valid = v;
    value = val[7:0];
    start = st;
    model_step(v, val & 255, st);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic config_burst(input int len, input int sd, input int on, input int off);
    length = len[15:0];
    seed = sd[7:0];
    on_cycles = on[3:0];
    off_cycles = off[3:0];
  endtask

  // Well-behaved source: holds the next expected value until it is taken
  task automatic run_src(input int max_cycles);
    int c;
    c = 0;
    while (!done && c < max_cycles) begin
      applyStimulus(1'b1, model_next(), 1'b0);
      c++;
    end
    chk("burst_completes", done, 1);
  endtask

  // Called at posedge+1: assert reset between edges and check the asynchronous clear
  task automatic async_reset();
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_beats", beats, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_violation", violation, 0);
    chk("rst_first_bad", first_bad, 0);
    checkOutput();
    reset_n = 1'b1;
  endtask

  typedef struct {
    int len; int sd; int on; int off;
    int bad_a; int val_a; int bad_b; int val_b;
    int exp_cycles; int exp_beats; int exp_mis; int exp_fb;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, nacc, v;
    bit r;

    tbl[0] = '{4, 'h10, 1, 0, -1, 0, -1, 0, 4, 4, 0, 0};
    tbl[1] = '{6, 'h00, 2, 3, -1, 0, -1, 0, 12, 6, 0, 0};
    tbl[2] = '{4, 'hFE, 1, 0, -1, 0, -1, 0, 4, 4, 0, 0};
    tbl[3] = '{4, 'hFE, 1, 0, 2, 'h05, 3, 'h77, 4, 4, 1, 'h05};
    tbl[4] = '{0, 'h33, 1, 0, -1, 0, -1, 0, 0, 0, 0, 0};
    tbl[5] = '{3, 'h01, 0, 0, -1, 0, -1, 0, 3, 3, 0, 0};
    tbl[6] = '{3, 'h01, 0, 1, -1, 0, -1, 0, 5, 3, 0, 0};
    tbl[7] = '{5, 'h80, 3, 1, -1, 0, -1, 0, 6, 5, 0, 0};

    model_reset();
    #3;
    checkOutput();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    checkOutput();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      config_burst(tbl[i].len, tbl[i].sd, tbl[i].on, tbl[i].off);
      applyStimulus(1'b0, 0, 1'b1);
      cyc = 0;
      nacc = 0;
      while (!done && cyc < 300) begin
        if (nacc == tbl[i].bad_a) v = tbl[i].val_a;
        else if (nacc == tbl[i].bad_b) v = tbl[i].val_b;
        else v = (tbl[i].sd + nacc) % 256;
        r = ready;
        applyStimulus(1'b1, v, 1'b0);
        cyc++;
        if (r) nacc++;
      end
      chk("tbl_cycles", cyc, tbl[i].exp_cycles);
      chk("tbl_done", done, 1);
      chk("tbl_busy", busy, 1);
      chk("tbl_ready", ready, 0);
      chk("tbl_beats", beats, tbl[i].exp_beats);
      chk("tbl_mismatch", mismatch, tbl[i].exp_mis);
      chk("tbl_first_bad", first_bad, tbl[i].exp_fb);
      chk("tbl_violation", violation, 0);
    end

    // Pending beat withdrawn during an OFF phase
    applyStimulus(1'b0, 0, 1'b0);
    config_burst(8, 0, 1, 2);
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    chk("viol_withdraw", violation, 1);
    run_src(100);

    // Pending beat changes value during an OFF phase
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b1, 9, 1'b0);
    chk("viol_change", violation, 1);
    run_src(100);

    // Withdraw/change right after ready=1 edges is legal
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b1, 0, 1'b0);
    applyStimulus(1'b0, 7, 1'b0);
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b1, 1, 1'b0);
    applyStimulus(1'b0, 3, 1'b0);
    applyStimulus(1'b0, 3, 1'b0);
    applyStimulus(1'b1, 2, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    chk("no_viol_legal", violation, 0);
    run_src(100);
    chk("no_viol_end", violation, 0);
    chk("legal_beats", beats, 8);

    // start while running is ignored
    applyStimulus(1'b0, 0, 1'b0);
    config_burst(4, 'h20, 1, 1);
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b1, 'h20, 1'b0);
    config_burst(9, 'h40, 2, 0);
    applyStimulus(1'b1, 'h21, 1'b1);
    run_src(100);
    chk("ign_start_beats", beats, 4);
    chk("ign_start_mismatch", mismatch, 0);
    chk("ign_start_violation", violation, 0);

    // Reset mid-burst, then a clean new burst
    applyStimulus(1'b0, 0, 1'b0);
    config_burst(5, 'h50, 1, 0);
    applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b1, 'h50, 1'b0);
    applyStimulus(1'b1, 'h99, 1'b0);
    chk("pre_rst_beats", beats, 2);
    chk("pre_rst_mismatch", mismatch, 1);
    async_reset();
    config_burst(3, 'h07, 1, 0);
    applyStimulus(1'b0, 0, 1'b1);
    run_src(100);
    chk("post_rst_beats", beats, 3);
    chk("post_rst_mismatch", mismatch, 0);
    applyStimulus(1'b0, 0, 1'b0);
    chk("post_rst_idle_busy", busy, 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399, 0) == 0) begin
        async_reset();
      end else begin
        config_burst($urandom_range(11, 0), $urandom_range(255, 0),
                     $urandom_range(4, 0), $urandom_range(3, 0));
        applyStimulus($urandom_range(9, 0) < 7,
                      ($urandom_range(9, 0) < 9) ? model_next() : $urandom_range(255, 0),
                      $urandom_range(7, 0) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
